// File: rtl/stage_fetchq_pkg.sv
// stage_fetchq shared types and constants.
// Entry layout, reset vector and filler instruction.
package stage_fetchq_pkg;

  localparam int XLEN_DEF = 32;

  localparam logic [XLEN_DEF-1:0] RESET_VECTOR =
    32'h0000_0100;

  localparam logic [XLEN_DEF-1:0] NOP_INSTR =
    32'h0000_0013;

  typedef struct packed {
    logic [XLEN_DEF-1:0] pc;
    logic [XLEN_DEF-1:0] instr;
  } fq_entry_t;

  function automatic fq_entry_t fq_pack(
    input logic [XLEN_DEF-1:0] pc,
    input logic [XLEN_DEF-1:0] instr
  );
    fq_entry_t e;
    e.pc    = pc;
    e.instr = instr;
    return e;
  endfunction

endpackage

// File: rtl/fetchq_mem.sv
// Fetch queue storage: DEPTH x W register array.
// One write port, one combinational read port, no reset.
module fetchq_mem #(
  parameter int DEPTH = 4,
  parameter int W     = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  // Write the addressed entry when enabled.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/stage_fetchq.sv
// Instruction queue between fetch and decode.
// FETCHQ_BYPASS_EN: pass words through when empty.
module stage_fetchq
  import stage_fetchq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = XLEN_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [XLEN-1:0]          in_pc,
  input  logic [XLEN-1:0]          in_instr,
  input  logic                     flush,
  output logic                     out_valid,
  output logic [XLEN-1:0]          out_pc,
  output logic [XLEN-1:0]          out_instr,
  input  logic                     out_ready,
  output logic                     stall_out,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int EW = 2 * XLEN;

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic          ovf;

  logic          empty;
  logic          full;
  logic          byp;
  logic          pop;
  logic          push;
  logic          byp_take;
  logic          we;
  logic          rd_adv;
  logic [EW-1:0] wdata;
  logic [EW-1:0] rdata;

  assign empty = (cnt == '0);
  assign full  = (cnt == CW'(DEPTH));

`ifdef FETCHQ_BYPASS_EN
  assign byp = empty && in_valid && !flush;
`else
  assign byp = 1'b0;
`endif

  assign out_valid = !empty || byp;
  assign pop       = out_valid && out_ready;
  assign push      = in_valid && !flush
                   && (!full || pop);
  assign byp_take  = byp && pop;
  assign we        = push && !byp_take;
  assign rd_adv    = pop && !byp_take;
  assign wdata     = {in_pc, in_instr};

  fetchq_mem #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_mem (
    .clk   (clk),
    .we    (we),
    .waddr (wr_ptr),
    .wdata (wdata),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

  // Head selection: bypassed input, stored head, or zero.
  always_comb begin
    out_pc    = '0;
    out_instr = '0;
    if (byp) begin
      out_pc    = in_pc;
      out_instr = in_instr;
    end else if (!empty) begin
      out_pc    = rdata[EW-1:XLEN];
      out_instr = rdata[XLEN-1:0];
    end
  end

  // Pointer and occupancy bookkeeping; flush empties the queue.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (we) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (rd_adv) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end

  // Sticky error when a word arrives with no room.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (in_valid && !flush && !push) begin
      ovf <= 1'b1;
    end
  end

  assign count     = cnt;
  assign overflow  = ovf;
  assign stall_out = (cnt >= CW'(DEPTH-1));

endmodule

// File: doc/stage_fetchq.md
Name: stage_fetchq

Overview:
- Instruction queue directly downstream of the fetch stage.
- Captures each (pc, instruction) pair returned by synchronous instruction memory for the fetch stage's present PC.
- Buffers up to DEPTH entries and presents them in order to decode with a valid/ready handshake.
- Drives the fetch stage's stall input when space runs low, and discards all buffered words on a redirect (jump/flush).

Parameters:
- DEPTH, 4, number of queue entries; power of two, minimum 2.
- XLEN, 32, width of pc and instruction words.

Ports:
- clk  input  1  clock
- rst  input  1  reset
- in_valid  input  1  in_pc/in_instr carry a fetched word this cycle
- in_pc  input  XLEN  pc of the fetched word (fetch stage present PC)
- in_instr  input  XLEN  instruction word from instruction memory
- flush  input  1  redirect; drop all queued and incoming words
- out_valid  output  1  head entry available to decode
- out_pc  output  XLEN  pc of head entry
- out_instr  output  XLEN  instruction of head entry
- out_ready  input  1  decode consumes head this cycle when out_valid=1
- stall_out  output  1  to fetch stall input; hold PC
- count  output  $clog2(DEPTH+1)  current occupancy
- overflow  output  1  sticky error: word arrived with no space

Behaviour:
- Reset: rst is synchronous, active-high, and dominates flush and all traffic. After reset: count=0, read/write pointers=0, out_valid=0, stall_out=0, overflow=0, out_pc=0, out_instr=0.
- Storage: circular buffer with DEPTH entries.
  - wr_ptr and rd_ptr are $clog2(DEPTH) bits and wrap naturally modulo DEPTH.
  - count is separate and ranges 0..DEPTH.
- pop = out_valid && out_ready.
- push = in_valid && !flush && (count < DEPTH || pop). Entry at wr_ptr is written with {in_pc, in_instr}; wr_ptr increments.
- Simultaneous push and pop: count unchanged, both pointers advance. Legal at count=DEPTH and at count=0 (only with bypass; see Optional Feature).
- count_next = count + push - pop.
- out_valid = (count != 0); out_pc/out_instr = entry at rd_ptr.
  - Latency: word written at edge N is visible to decode in cycle N+1.
  - The head entry holds stable while out_ready=0.
- stall_out = (count >= DEPTH-1), decoded from registered count with no combinational path from inputs.
  - Reserves one slot for the word already in flight from memory during the stall's first cycle.
- overflow: set when in_valid && !flush && !push; stays set until rst. The word is dropped and queue state is unchanged.
- flush: at the next edge, count=0 and rd_ptr=wr_ptr=0.
  - out_valid falls the following cycle.
  - That cycle's input is discarded and any pop is ignored.
  - overflow is not cleared.
  - stall_out deasserts the cycle after flush.
  - Back-to-back flush cycles keep the queue empty.
- DEPTH=2: stall_out asserts whenever count >= 1.

Optional Feature:
- Macro: FETCHQ_BYPASS_EN.
- Defined: when count=0 and in_valid && !flush, out_valid=1 and out_pc/out_instr=in_pc/in_instr combinationally in the same cycle.
  - If out_ready=1, the word is consumed and not written (count stays 0).
  - If out_ready=0, it is written normally.
- Undefined: no combinational path from in_* to out_*; one-cycle minimum latency as above.

Decomposition:
- Shared package holds:
  - XLEN default.
  - fetchq entry struct {pc, instr}.
  - RESET_VECTOR, so benches can check first pc.
  - NOP instruction constant, for benches and decode filler.
- One natural sub-module: fetchq_mem, the DEPTH x 2*XLEN register array with a single write port (we, waddr, wdata) and a combinational read port (raddr, rdata). It has no reset. Outputs are forced to 0 via out_valid gating only for the post-reset value.

Test Plan:
- Fill/drain: 4 consecutive in_valid words (pc 0x100..0x10C), out_ready=0. Required: count 1,2,3,4; stall_out rises when count reaches 3. Then out_ready=1: pcs come out 0x100,0x104,0x108,0x10C in order; out_valid falls after the 4th.
- Full with simultaneous push/pop: count=4, in_valid=1 with pc 0x200, out_ready=1. Required: head 0x100 popped, 0x200 enqueued, count stays 4, overflow=0.
- Overflow: count=4, out_ready=0, in_valid=1. Required: overflow=1 next cycle and stays set through a flush; count stays 4; head unchanged; cleared only by rst.
- Flush mid-stream: count=3, flush=1 with in_valid=1 (pc 0x300) and out_ready=1. Required: next cycle count=0, out_valid=0, stall_out=0; 0x300 never appears at the output. The next word (pc 0x400) emerges as head.
- Pointer wrap: stream 10 words with out_ready toggling 1/0 each cycle. Required: output pc sequence matches input exactly, with no loss or duplication across pointer wraparound.
- Reset mid-operation and bypass: rst with count=2 and flush=1. Required: next cycle all outputs 0. With FETCHQ_BYPASS_EN, empty queue, in_valid=1, pc 0x500, out_ready=1: out_valid=1 and out_pc=0x500 in the same cycle, count stays 0.
